// File: rtl/n64_cmd_decoder.sv
// Joybus command decoder for one N64 port: measures bit low times, assembles the
// command frame, classifies it, and tracks rumble-pak writes.
module n64_cmd_decoder #(
    parameter int CYC_PER_US = 12,
    parameter int SAMPLE_US  = 2,
    parameter int LOW_MAX_US = 4,
    parameter int IDLE_US    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_in,
    input  logic        tx_busy,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_addr,
    output logic        frame_err,
    output logic        rumble,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SAMPLE_N  = CNT_W'(SAMPLE_US * CYC_PER_US);
    localparam logic [CNT_W-1:0] LOW_MAX_N = CNT_W'(LOW_MAX_US * CYC_PER_US);
    localparam logic [CNT_W-1:0] IDLE_N    = CNT_W'(IDLE_US * CYC_PER_US);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             line_q;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [8:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sh_cmd_q, sh_cmd_d;
    logic [15:0]      sh_addr_q, sh_addr_d;
    logic [7:0]       sh_data_q, sh_data_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       cmd_code_q, cmd_code_d;
    logic [15:0]      cmd_addr_q, cmd_addr_d;
    logic             rumble_q, rumble_d;

    logic             fall, rise, bit_in;
    logic [9:0]       bit_idx;
    logic [8:0]       bit_cnt_inc;

    // Only exact lengths for known codes pass; a saturated count (511) never matches.
    function automatic logic len_ok(input logic [7:0] code, input logic [8:0] n);
        case (code)
            8'h00, 8'h01, 8'hFF: len_ok = (n == 9'd9);
            8'h02:               len_ok = (n == 9'd25);
            8'h03:               len_ok = (n == 9'd281);
            default:             len_ok = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        high_cnt_d  = high_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sh_cmd_d    = sh_cmd_q;
        sh_addr_d   = sh_addr_q;
        sh_data_d   = sh_data_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        cmd_addr_d  = cmd_addr_q;
        rumble_d    = rumble_q;

        fall        = line_q & ~line_in;
        rise        = ~line_q & line_in;
        bit_in      = (low_cnt_q < SAMPLE_N);
        bit_idx     = {1'b0, bit_cnt_q} + 10'd1;
        bit_cnt_inc = (bit_cnt_q == 9'h1FF) ? bit_cnt_q : bit_cnt_q + 9'd1;

        // Rumble follows the registered strobe, so it lands one cycle after cmd_valid.
        if (cmd_valid_q && (cmd_code_q == 8'h03) && ((cmd_addr_q & 16'hFFE0) == 16'hC000)) begin
            rumble_d = sh_data_q[0];
        end

        if (tx_busy) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        bit_cnt_d = '0;
                        low_cnt_d = CNT_W'(1);
                        state_d   = S_LOW;
                    end
                end
                S_LOW: begin
                    if (low_cnt_q >= LOW_MAX_N) begin
                        frame_err_d = 1'b1;
                        high_cnt_d  = '0;
                        state_d     = S_WAIT;
                    end else if (rise) begin
                        if (bit_idx <= 10'd8) begin
                            sh_cmd_d = {sh_cmd_q[6:0], bit_in};
                        end else if (bit_idx <= 10'd24) begin
                            sh_addr_d = {sh_addr_q[14:0], bit_in};
                        end else if (bit_idx <= 10'd32) begin
                            sh_data_d = {sh_data_q[6:0], bit_in};
                        end
                        bit_cnt_d  = bit_cnt_inc;
                        high_cnt_d = CNT_W'(1);
                        state_d    = S_HIGH;
                    end else begin
                        low_cnt_d = low_cnt_q + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        low_cnt_d = CNT_W'(1);
                        state_d   = S_LOW;
                    end else if (high_cnt_q >= IDLE_N) begin
                        if (len_ok(sh_cmd_q, bit_cnt_q)) begin
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = sh_cmd_q;
                            cmd_addr_d  = ((sh_cmd_q == 8'h02) || (sh_cmd_q == 8'h03)) ? sh_addr_q : 16'h0000;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        high_cnt_d = high_cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!line_in) begin
                        high_cnt_d = '0;
                    end else if (high_cnt_q >= IDLE_N) begin
                        state_d = S_IDLE;
                    end else begin
                        high_cnt_d = high_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            line_q      <= 1'b1;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sh_cmd_q    <= '0;
            sh_addr_q   <= '0;
            sh_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_addr_q  <= '0;
            rumble_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_in;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_cmd_q    <= sh_cmd_d;
            sh_addr_q   <= sh_addr_d;
            sh_data_q   <= sh_data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            cmd_code_q  <= cmd_code_d;
            cmd_addr_q  <= cmd_addr_d;
            rumble_q    <= rumble_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_addr  = cmd_addr_q;
    assign rumble    = rumble_q;
    assign dbg_state = state_q;

endmodule
